sda_ctrl: RTL and testbench
===========================

Name: sda_ctrl

Overview:
- I2C data-line engine sitting directly downstream of the SCL generator; consumes its free-running SCL_BUS level and drives/samples SDA.
- Software loads a command word from MDR via LD_SDAR.
- The block emits an optional START, shifts one byte out (write) or in (read), handles the ACK bit, and emits an optional STOP.
- Status is read back through SDAR.
- SDA is open-drain: the block only pulls low (SDA_OE=1) or releases.

Parameters:
- HOLD, 16'h007D, clk cycles from a sampled SCL edge to the SDA action point. Default is mid-phase for a 250-cycle half period. Must be less than the SCL half period.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- SCL_BUS  input  1  SCL level from the SCL generator
- SDA_IN  input  1  sampled SDA bus level
- MDR  input  16  command word; [7:0] tx byte, [8] START, [9] STOP, [10] READ, [11] master ACK value for read (0=ACK)
- LD_SDAR  input  1  load strobe for the command word
- SDA_OE  output  1  1 = pull SDA low; 0 = release
- SDAR  output  16  status; [7:0] rx byte, [8] slave ACK sampled (0=ACK), [14] overrun, [15] busy
- WR  output  1  one-cycle pulse, registered, in the cycle after an accepted load
- DONE  output  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset (async, reset_n=0):
  - SDA_OE=0, SDAR=16'h0000, WR=0, DONE=0.
  - State=IDLE; internal scl_q=1, hold counter=0.
  - Reset mid-transfer releases SDA immediately and abandons the transfer.
- Edge detect:
  - scl_q <= SCL_BUS each clk.
  - rise = SCL_BUS & ~scl_q; fall = ~SCL_BUS & scl_q.
  - On rise or fall, the counter loads HOLD. The action for that phase fires when the counter reaches 0, i.e. HOLD+1 clk cycles after the edge cycle.
  - Actions are called "mid-low" or "mid-high".
- Load:
  - In IDLE, LD_SDAR=1 latches MDR[11:0], sets SDAR[15]=1, clears SDAR[14], and pulses WR.
  - While busy, LD_SDAR is ignored except that SDAR[14]=1 is set; WR is not pulsed.
- States:
  - IDLE -> START if the START bit is set, else -> BIT.
  - START:
    - First rise: mid-high sets SDA_OE=1 (SDA falls while SCL high).
    - Then -> BIT.
  - BIT (count 7 down to 0):
    - Mid-low: SDA_OE = READ ? 0 : ~tx[i].
    - Mid-high: if READ, rx[i] <= SDA_IN.
    - After the mid-high of bit 0 -> ACK.
  - ACK:
    - Mid-low: SDA_OE = READ ? ~MDR[11] : 0.
    - Mid-high: if write, SDAR[8] <= SDA_IN. In both cases SDAR[7:0] <= rx.
    - Then -> STOP if the STOP bit is set, else -> FIN.
  - STOP:
    - Mid-low: SDA_OE=1.
    - Mid-high: SDA_OE=0 (SDA rises while SCL high).
    - Then -> FIN.
  - FIN:
    - If arriving from ACK, waits for the next mid-low and then sets SDA_OE=0.
    - Then: SDAR[15]=0, DONE=1 for one cycle, -> IDLE.
- SCL stalled:
  - If SCL_BUS holds constant (generator disabled), the engine freezes in its current state with SDA_OE held.
  - There is no timeout.
- Edge arriving before the counter expires:
  - The counter reloads. The pending action is dropped and the state does not advance for it.
- rx byte: shift register, MSB first. SDAR[7:0] is updated only in ACK.
- SDAR[13:9] always reads 0.

Test Plan:
- Write with START+STOP (MDR=16'h03A5), SCL half period 250:
  - SDA_OE rises mid-high of the first SCL high.
  - SDA line shows 1,0,1,0,0,1,0,1 at successive SCL rises.
  - Slave holds SDA_IN=0 on the 9th rise -> SDAR[8]=0.
  - STOP: SDA released mid-high; DONE pulses once; SDAR[15]=0.
- Read with NACK (MDR=16'h0C00):
  - SDA_IN driven 8'h3C across the bits -> SDA_OE=0 throughout the byte.
  - SDA_OE=0 at the ACK bit (MDR[11]=1, NACK).
  - SDAR[7:0]=8'h3C; no START edge.
- Write, slave NACK (MDR=16'h0155, SDA_IN=1 at ACK) -> SDAR[8]=1; SDA_OE released after the next mid-low; DONE pulses.
- LD_SDAR while busy -> SDAR[14]=1, WR stays 0, transfer byte unchanged; the next accepted load clears SDAR[14].
- reset_n pulsed low during bit 3 -> SDA_OE=0, SDAR=16'h0000 asynchronously; a new load after release runs a clean transfer.
- SCL_BUS held high for 2000 cycles mid-byte -> no state change, SDA_OE constant; resumes correctly when SCL restarts.

Source files
------------

// File: rtl/sda_ctrl.sv
// I2C SDA engine: follows the SCL generator's level, emits optional START/STOP,
// shifts one byte out or in, handles the ACK bit and reports status through SDAR.
module sda_ctrl #(
  parameter logic [15:0] HOLD = 16'h007D
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCL_BUS,
  input  logic        SDA_IN,
  input  logic [15:0] MDR,
  input  logic        LD_SDAR,
  output logic        SDA_OE,
  output logic [15:0] SDAR,
  output logic        WR,
  output logic        DONE
);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, FIN} state_t;

  state_t      state, state_nxt;

  logic        scl_q, armed, phase_hi;
  logic [15:0] hold_cnt;
  logic        rise, fall, scl_edge, act_low, act_high;

  logic [7:0]  tx_byte, rx_sh, rx_byte;
  logic        stop_en, read_en, mack;
  logic [2:0]  bit_idx;
  logic        low_seen, fin_wait, busy, ovr, ack_bit;

  logic        load_cmd, ovr_set, oe_we, oe_val, low_mark, low_clear;
  logic        bit_dec, rx_shift, ack_cap, rx_cap, fin_arm, finish;
  logic        unused_mdr;

  assign unused_mdr = ^MDR[15:12];

  assign rise     = SCL_BUS & ~scl_q;
  assign fall     = ~SCL_BUS & scl_q;
  assign scl_edge = rise | fall;
  assign act_low  = armed & (hold_cnt == 16'd0) & ~scl_edge & ~phase_hi;
  assign act_high = armed & (hold_cnt == 16'd0) & ~scl_edge & phase_hi;

  // A new SCL edge always re-arms the counter, dropping any action still pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q    <= 1'b1;
      hold_cnt <= 16'd0;
      armed    <= 1'b0;
      phase_hi <= 1'b0;
    end else begin
      scl_q <= SCL_BUS;
      if (scl_edge) begin
        hold_cnt <= HOLD;
        armed    <= 1'b1;
        phase_hi <= SCL_BUS;
      end else if (armed) begin
        if (hold_cnt == 16'd0) armed <= 1'b0;
        else                   hold_cnt <= hold_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (LD_SDAR) state_nxt = MDR[8] ? START : BIT;
      START:   if (act_high) state_nxt = BIT;
      BIT:     if (act_high && low_seen && bit_idx == 3'd0) state_nxt = ACK;
      ACK:     if (act_high && low_seen) state_nxt = stop_en ? STOP : FIN;
      STOP:    if (act_high && low_seen) state_nxt = FIN;
      FIN:     if (!fin_wait || act_low) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A mid-high only counts once the matching mid-low of the same bit has been seen.
  always_comb begin
    load_cmd  = 1'b0;
    ovr_set   = 1'b0;
    oe_we     = 1'b0;
    oe_val    = 1'b0;
    low_mark  = 1'b0;
    low_clear = 1'b0;
    bit_dec   = 1'b0;
    rx_shift  = 1'b0;
    ack_cap   = 1'b0;
    rx_cap    = 1'b0;
    fin_arm   = 1'b0;
    finish    = 1'b0;
    if (state == IDLE) load_cmd = LD_SDAR;
    else               ovr_set  = LD_SDAR;
    case (state)
      START: begin
        if (act_high) begin
          oe_we  = 1'b1;
          oe_val = 1'b1;
        end
      end
      BIT: begin
        if (act_low) begin
          oe_we    = 1'b1;
          oe_val   = read_en ? 1'b0 : ~tx_byte[bit_idx];
          low_mark = 1'b1;
        end
        if (act_high && low_seen) begin
          low_clear = 1'b1;
          rx_shift  = read_en;
          bit_dec   = 1'b1;
        end
      end
      ACK: begin
        if (act_low) begin
          oe_we    = 1'b1;
          oe_val   = read_en ? ~mack : 1'b0;
          low_mark = 1'b1;
        end
        if (act_high && low_seen) begin
          low_clear = 1'b1;
          ack_cap   = ~read_en;
          rx_cap    = 1'b1;
          fin_arm   = ~stop_en;
        end
      end
      STOP: begin
        if (act_low) begin
          oe_we    = 1'b1;
          oe_val   = 1'b1;
          low_mark = 1'b1;
        end
        if (act_high && low_seen) begin
          oe_we     = 1'b1;
          oe_val    = 1'b0;
          low_clear = 1'b1;
        end
      end
      FIN: begin
        if (!fin_wait || act_low) begin
          oe_we  = 1'b1;
          oe_val = 1'b0;
          finish = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      SDA_OE   <= 1'b0;
      WR       <= 1'b0;
      DONE     <= 1'b0;
      tx_byte  <= 8'h00;
      stop_en  <= 1'b0;
      read_en  <= 1'b0;
      mack     <= 1'b0;
      bit_idx  <= 3'd7;
      rx_sh    <= 8'h00;
      rx_byte  <= 8'h00;
      ack_bit  <= 1'b0;
      low_seen <= 1'b0;
      fin_wait <= 1'b0;
      busy     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      WR   <= load_cmd;
      DONE <= finish;
      if (load_cmd) begin
        tx_byte <= MDR[7:0];
        stop_en <= MDR[9];
        read_en <= MDR[10];
        mack    <= MDR[11];
        bit_idx <= 3'd7;
        busy    <= 1'b1;
        ovr     <= 1'b0;
      end
      if (ovr_set) ovr <= 1'b1;
      if (oe_we) SDA_OE <= oe_val;
      if (low_mark)                   low_seen <= 1'b1;
      else if (low_clear || load_cmd) low_seen <= 1'b0;
      if (bit_dec)  bit_idx <= bit_idx - 3'd1;
      if (rx_shift) rx_sh   <= {rx_sh[6:0], SDA_IN};
      if (ack_cap)  ack_bit <= SDA_IN;
      if (rx_cap)   rx_byte <= rx_sh;
      if (fin_arm)     fin_wait <= 1'b1;
      else if (finish) fin_wait <= 1'b0;
      if (finish) busy <= 1'b0;
    end
  end

  assign SDAR = {busy, ovr, 5'b00000, ack_bit, rx_byte};

endmodule

// File: tb/tb_sda_ctrl.sv
// Bench for sda_ctrl: a free-running SCL source, an open-drain slave model and a
// transfer-level reference that predicts the bus bits and the final status word.
module tb_sda_ctrl;

  localparam int HOLD = 125;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        SCL_BUS   = 1'b1;
  logic        SDA_IN;
  logic [15:0] MDR       = 16'h0000;
  logic        LD_SDAR   = 1'b0;
  logic        SDA_OE, WR, DONE;
  logic [15:0] SDAR;

  logic        slavePull = 1'b0;
  logic        sclRun    = 1'b1;
  int          halfPeriod = 250;
  int          phaseCnt  = 0;
  int          testCount = 0;
  int          failCount = 0;
  int          doneCount = 0;
  logic [7:0]  lastRx    = 8'h00;
  logic        lastAck   = 1'b0;

  sda_ctrl #(.HOLD(16'(HOLD))) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .SCL_BUS (SCL_BUS),
    .SDA_IN  (SDA_IN),
    .MDR     (MDR),
    .LD_SDAR (LD_SDAR),
    .SDA_OE  (SDA_OE),
    .SDAR    (SDAR),
    .WR      (WR),
    .DONE    (DONE)
  );

  assign SDA_IN = ~(SDA_OE | slavePull);

  always #5 clk = ~clk;

  // SCL source: toggles every halfPeriod clocks and simply holds its level when stopped.
  always @(posedge clk) begin
    if (sclRun) begin
      if (phaseCnt >= halfPeriod - 1) begin
        SCL_BUS  <= ~SCL_BUS;
        phaseCnt <= 0;
      end else begin
        phaseCnt <= phaseCnt + 1;
      end
    end
  end

  always @(negedge clk) if (DONE === 1'b1) doneCount++;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitScl(input logic lvl, input string tag);
    int n = 0;
    while (SCL_BUS !== lvl && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_in_time"}, 16'(n < 4000), 16'h0001);
  endtask

  task automatic applyStimulus(input logic [15:0] cmd);
    LD_SDAR = 1'b1;
    MDR     = cmd;
    @(negedge clk);
    LD_SDAR = 1'b0;
  endtask

  // One transfer: load just after an SCL fall, then check every SCL rise against the
  // bits the command and the slave byte imply, and the status word at DONE.
  task automatic runTransfer(input logic [15:0] cmd, input logic [7:0] slaveByte,
                             input logic slaveAck, input int stallRise,
                             input int busyRise, input int resetRise);
    logic rd;
    logic expOvr;
    logic oeHold;
    logic changed;
    int   d0;
    int   dStall;
    int   n;
    rd     = cmd[10];
    expOvr = 1'b0;
    d0     = doneCount;
    waitScl(1'b1, "sync_hi");
    waitScl(1'b0, "sync_lo");
    waitClk(3);
    applyStimulus(cmd);
    checkOutput("load_accept", {13'b0, WR, SDAR[15:14]}, 16'h0006);
    waitClk(1);
    checkOutput("wr_single", 16'(WR), 16'h0000);
    if (cmd[8]) begin
      waitScl(1'b1, "start_rise");
      waitClk(2);
      checkOutput("start_pre", 16'(SDA_OE), 16'h0000);
      waitClk(HOLD + 4);
      checkOutput("start_mid_high", 16'(SDA_OE), 16'h0001);
    end
    for (int r = 1; r <= 9; r++) begin
      waitScl(1'b0, "bit_lo");
      if (r <= 8) slavePull = rd & ~slaveByte[8 - r];
      else        slavePull = ~rd & ~slaveAck;
      waitScl(1'b1, "bit_hi");
      waitClk(2);
      if (r <= 8) begin
        if (rd) checkOutput($sformatf("rd_oe_b%0d", 8 - r), 16'(SDA_OE), 16'h0000);
        else    checkOutput($sformatf("wr_line_b%0d", 8 - r), 16'(SDA_IN), 16'(cmd[8 - r]));
      end else begin
        checkOutput("ack_oe", 16'(SDA_OE), 16'(rd & ~cmd[11]));
      end
      if (r == resetRise) begin
        #3 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_oe", 16'(SDA_OE), 16'h0000);
        checkOutput("async_rst_sdar", SDAR, 16'h0000);
        waitClk(3);
        reset_n   = 1'b1;
        slavePull = 1'b0;
        lastRx    = 8'h00;
        lastAck   = 1'b0;
        return;
      end
      if (r == busyRise) begin
        applyStimulus(cmd ^ 16'h04FF);
        checkOutput("busy_wr", 16'(WR), 16'h0000);
        checkOutput("busy_overrun", 16'(SDAR[14]), 16'h0001);
        expOvr = 1'b1;
      end
      if (r == stallRise) begin
        waitClk(HOLD + 10);
        oeHold  = SDA_OE;
        dStall  = doneCount;
        changed = 1'b0;
        sclRun  = 1'b0;
        for (int k = 0; k < 2000; k++) begin
          @(negedge clk);
          if (SDA_OE !== oeHold || SDAR[15] !== 1'b1 || doneCount != dStall) changed = 1'b1;
        end
        checkOutput("stall_frozen", 16'(changed), 16'h0000);
        sclRun = 1'b1;
      end
    end
    waitScl(1'b0, "ack_lo");
    slavePull = 1'b0;
    if (rd) lastRx  = slaveByte;
    else    lastAck = slaveAck;
    if (cmd[9]) begin
      waitClk(HOLD + 4);
      checkOutput("stop_mid_low", 16'(SDA_OE), 16'h0001);
      waitScl(1'b1, "stop_hi");
      waitClk(2);
      checkOutput("stop_pre", 16'(SDA_OE), 16'h0001);
    end
    n = 0;
    while (DONE !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_in_time", 16'(n < 2000), 16'h0001);
    checkOutput("final_sdar", SDAR, {1'b0, expOvr, 5'b00000, lastAck, lastRx});
    checkOutput("final_oe", 16'(SDA_OE), 16'h0000);
    checkOutput("done_scl_level", 16'(SCL_BUS), 16'(cmd[9]));
    waitClk(5);
    checkOutput("done_once", 16'(doneCount - d0), 16'h0001);
  endtask

  initial begin
    logic [15:0] cmdR;
    waitClk(3);
    checkOutput("reset_oe", 16'(SDA_OE), 16'h0000);
    checkOutput("reset_sdar", SDAR, 16'h0000);
    checkOutput("reset_pulses", 16'({WR, DONE}), 16'h0000);
    reset_n = 1'b1;
    waitClk(2);

    runTransfer(16'h03A5, 8'h00, 1'b0, 0, 0, 0);
    runTransfer(16'h0C00, 8'h3C, 1'b0, 0, 0, 0);
    runTransfer(16'h0155, 8'h00, 1'b1, 0, 0, 0);
    runTransfer(16'h0266, 8'h00, 1'b0, 0, 4, 0);
    runTransfer(16'h0400, 8'h96, 1'b1, 5, 0, 0);
    runTransfer(16'h00A5, 8'h00, 1'b0, 0, 0, 5);
    runTransfer(16'h03C3, 8'h00, 1'b0, 0, 0, 0);

    halfPeriod = 150;
    for (int i = 0; i < 5; i++) begin
      cmdR = {4'h0, 4'($urandom_range(0, 15)), 8'($urandom)};
      runTransfer(cmdR, 8'($urandom), 1'($urandom), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
